// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the gray_counter block.
// Latency: none (pure functions).
// Backpressure: not applicable.
//
// Functions work on a fixed maximum width. Callers zero-extend their
// WIDTH-bit value into GRAY_MAX_W bits and truncate the result back.
// Zero upper bits do not disturb either conversion.
package gray_pkg;

    // Upper bound on counter width supported by the helpers below.
    localparam int GRAY_MAX_W = 64;

    // Binary to reflected Gray code.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary by prefix-XOR from the MSB down.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when exactly one bit of v is set (Hamming weight of one).
    function automatic logic popcount_is_one(input logic [GRAY_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - GRAY_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_counter_gray2bin_conv.sv
// Purpose: combinational Gray-to-binary converter for the load path.
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   gray_i  WIDTH-bit Gray-coded value
//   bin_o   WIDTH-bit binary equivalent
module gray2bin_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at and above it.
    // Written per bit so no bit depends on another output bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter.sv
// Purpose: registered up/down Gray counter with binary/Gray load and wrap pulse.
// Latency: one clock from sampled load/en to bin_out/gray_out/wrap.
// Backpressure: none; a step is taken on every edge with en high.
//
// Ports:
//   clk, rst_n          clock and async active-low reset
//   en, up              count enable and direction (1 = increment)
//   load, load_gray     load strobe (wins over en) and load_val format
//   load_val            value to load
//   bin_out, gray_out   registered binary and Gray views of the count
//   wrap                one-cycle pulse on an all-ones <-> zero count step
//   err                 sticky Gray adjacency error
//
// Optional: define GRAY_CHECK_EN to build the adjacency checker; otherwise
// err is tied to 0. WIDTH must be between 2 and gray_pkg::GRAY_MAX_W.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             step;
    logic [WIDTH-1:0] load_bin;

    gray2bin_conv #(
        .WIDTH(WIDTH)
    ) u_load_conv (
        .gray_i(load_val),
        .bin_o (load_bin)
    );

    // Next count: load > en > hold. wrap only on a count step.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        step   = 1'b0;
        if (load) begin
            cnt_d = load_gray ? load_bin : load_val;
        end else if (en) begin
            step = 1'b1;
            if (up) begin
                cnt_d  = cnt_q + WIDTH'(1);
                wrap_d = &cnt_q;
            end else begin
                cnt_d  = cnt_q - WIDTH'(1);
                wrap_d = ~|cnt_q;
            end
        end
    end

    // Gray view is registered from the next binary count so both views
    // change on the same edge and gray_out has no decode logic after the flop.
    assign gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(cnt_d)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = cnt_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

`ifdef GRAY_CHECK_EN
    // Adjacency checker. prev_gray_q captures gray_out as it was before a
    // step; chk_q marks the cycle right after a step whose predecessor was
    // also a count result (vld_q), so the pair is comparable. Loads break
    // the chain because a loaded value may legitimately jump.
    logic [WIDTH-1:0] prev_gray_q;
    logic             vld_q, vld_d;
    logic             chk_q, chk_d;
    logic             err_q, err_d;

    always_comb begin
        vld_d = vld_q;
        if (load) begin
            vld_d = 1'b0;
        end else if (step) begin
            vld_d = 1'b1;
        end
        chk_d = step & vld_q;
        err_d = err_q;
        if (chk_q && !popcount_is_one(GRAY_MAX_W'(gray_q ^ prev_gray_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray_q <= '0;
            vld_q       <= 1'b0;
            chk_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (step) begin
                prev_gray_q <= gray_q;
            end
            vld_q <= vld_d;
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Purpose: directed and random self-checking bench for gray_counter.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst_n;

    // WIDTH=4 instance signals
    logic       en, up, load, load_gray;
    logic [3:0] load_val;
    logic [3:0] bin_out, gray_out;
    logic       wrap, err;

    // WIDTH=8 instance signals
    logic       en8, up8, load8, load_gray8;
    logic [7:0] load_val8;
    logic [7:0] bin_out8, gray_out8;
    logic       wrap8, err8;

    int checks   = 0;
    int failures = 0;

    // Hand-written Gray sequence for a 4-bit up count from 0.
    logic [3:0] gexp [0:16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000,
                                4'b0000};

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_gray(load_gray),
        .load_val (load_val),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .wrap     (wrap),
        .err      (err)
    );

    gray_counter #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en8),
        .up       (up8),
        .load     (load8),
        .load_gray(load_gray8),
        .load_val (load_val8),
        .bin_out  (bin_out8),
        .gray_out (gray_out8),
        .wrap     (wrap8),
        .err      (err8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_g2b(input logic [7:0] g);
        logic [7:0] b;
        b = '0;
        for (int k = 7; k >= 0; k--) begin
            b[k] = g[k] ^ ((k == 7) ? 1'b0 : b[k+1]);
        end
        return b;
    endfunction

    initial begin
        logic [7:0] m_bin;
        logic       m_wrap;

        rst_n = 1'b0;
        en = 0; up = 0; load = 0; load_gray = 0; load_val = '0;
        en8 = 0; up8 = 0; load8 = 0; load_gray8 = 0; load_val8 = '0;

        #3;
        chk("rst_bin", 32'(bin_out), 32'h0);
        chk("rst_gray", 32'(gray_out), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        #9;
        rst_n = 1'b1;

        // Up count through a full wrap.
        en = 1; up = 1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("up_gray", 32'(gray_out), 32'(gexp[i]));
            chk("up_bin", 32'(bin_out), 32'(i % 16));
            chk("up_wrap", 32'(wrap), (i == 16) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 3; i++) tick();
        chk("pre_arst_bin", 32'(bin_out), 32'h3);

        // Asynchronous reset with no clock edge.
        rst_n = 1'b0;
        en = 0;
        #2;
        chk("arst_bin", 32'(bin_out), 32'h0);
        chk("arst_gray", 32'(gray_out), 32'h0);
        chk("arst_wrap", 32'(wrap), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        rst_n = 1'b1;

        // Down count from zero wraps to all-ones.
        en = 1; up = 0;
        tick();
        chk("dn_bin0", 32'(bin_out), 32'hF);
        chk("dn_gray0", 32'(gray_out), 32'h8);
        chk("dn_wrap0", 32'(wrap), 32'h1);
        tick();
        chk("dn_bin1", 32'(bin_out), 32'hE);
        chk("dn_gray1", 32'(gray_out), 32'h9);
        chk("dn_wrap1", 32'(wrap), 32'h0);
        en = 0;

        // Loads in both formats; loads of the extreme values never pulse wrap.
        load = 1; load_gray = 0; load_val = 4'b0101;
        tick();
        chk("ldb_bin", 32'(bin_out), 32'h5);
        chk("ldb_gray", 32'(gray_out), 32'h7);
        load_gray = 1; load_val = 4'b1101;
        tick();
        chk("ldg_bin", 32'(bin_out), 32'h9);
        chk("ldg_gray", 32'(gray_out), 32'hD);
        chk("ldg_wrap", 32'(wrap), 32'h0);
        load_gray = 0; load_val = 4'hF;
        tick();
        chk("ldF_bin", 32'(bin_out), 32'hF);
        chk("ldF_gray", 32'(gray_out), 32'h8);
        chk("ldF_wrap", 32'(wrap), 32'h0);
        load_val = 4'h0;
        tick();
        chk("ld0_bin", 32'(bin_out), 32'h0);
        chk("ld0_wrap", 32'(wrap), 32'h0);

        // Load wins over enable.
        en = 1; up = 1; load_val = 4'b0011;
        tick();
        chk("prio_bin", 32'(bin_out), 32'h3);
        chk("prio_gray", 32'(gray_out), 32'h2);
        chk("prio_wrap", 32'(wrap), 32'h0);

        // Hold.
        load = 0; en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_bin", 32'(bin_out), 32'h3);
            chk("hold_gray", 32'(gray_out), 32'h2);
            chk("hold_wrap", 32'(wrap), 32'h0);
        end

        // Direction change while enabled.
        en = 1; up = 1;
        tick();
        chk("dir_up_bin", 32'(bin_out), 32'h4);
        chk("dir_up_gray", 32'(gray_out), 32'h6);
        up = 0;
        tick();
        chk("dir_dn_bin", 32'(bin_out), 32'h3);
        chk("dir_dn_gray", 32'(gray_out), 32'h2);
        en = 0;
        chk("w4_err", 32'(err), 32'h0);

        // WIDTH=8 random run against a reference model; dut8 has been idle at 0.
        m_bin = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            en8        = ($urandom_range(0, 3) != 0);
            up8        = 1'($urandom_range(0, 1));
            load8      = ($urandom_range(0, 15) == 0);
            load_gray8 = 1'($urandom_range(0, 1));
            load_val8  = 8'($urandom_range(0, 255));
            m_wrap = 1'b0;
            if (load8) begin
                m_bin = load_gray8 ? model_g2b(load_val8) : load_val8;
            end else if (en8) begin
                if (up8) begin
                    m_wrap = (m_bin == 8'hFF);
                    m_bin  = m_bin + 8'd1;
                end else begin
                    m_wrap = (m_bin == 8'h00);
                    m_bin  = m_bin - 8'd1;
                end
            end
            tick();
            chk("r8_bin", 32'(bin_out8), 32'(m_bin));
            chk("r8_gray", 32'(gray_out8), 32'(m_bin ^ (m_bin >> 1)));
            chk("r8_wrap", 32'(wrap8), 32'(m_wrap));
            chk("r8_err", 32'(err8), 32'h0);
        end

`ifdef GRAY_CHECK_EN
        // Corrupt the Gray register while counting; the checker must latch err.
        load8 = 0; en8 = 1; up8 = 1;
        for (int i = 0; i < 3; i++) tick();
        force dut8.gray_q = 8'hA5;
        for (int i = 0; i < 3; i++) tick();
        release dut8.gray_q;
        tick();
        chk("force_err", 32'(err8), 32'h1);
        en8 = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("force_err_sticky", 32'(err8), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("force_err_rst", 32'(err8), 32'h0);
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
